mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter_lat_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM state and grant encodings, latency default,
// and the grant-selection helper used by the arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_e;

    localparam int MEM_LAT_DEF = 2;
    localparam int CNT_W       = 4;

    // Data wins by default because it belongs to the older instruction; with
    // round-robin enabled, a tie goes to whoever was not granted last.
    function automatic gnt_e arb_pick(input logic d_req,
                                      input logic if_req,
                                      input logic rr_en,
                                      input gnt_e last);
        if (rr_en && d_req && if_req) begin
            return (last == GNT_D) ? GNT_IF : GNT_D;
        end
        return d_req ? GNT_D : GNT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline/memory side bundle of mem_port_arbiter; the arbiter takes the slave view,
// the surrounding pipeline and memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;

    logic              d_rd_i;
    logic              d_wr_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_ack_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              stall_o;
    logic              proto_err_o;

    modport master (
        output if_req_i, if_addr_i,
        output d_rd_i, d_wr_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_rdata_o, if_ack_o,
        input  d_rdata_o, d_ack_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o, proto_err_o
    );

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_rd_i, d_wr_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_rdata_o, if_ack_o,
        output d_rdata_o, d_ack_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o, proto_err_o
    );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// mem_lat_counter: loadable down-counter that times the fixed memory latency;
// it saturates at zero and flags when it is there.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN to replace fixed data-first priority with round-robin grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
);

    state_e            state_q;
    state_e            state_d;
    gnt_e              gnt_q;
    gnt_e              gnt_pick;
    gnt_e              last_gnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    logic              d_req;
    logic              any_req;
    logic              grant;
    logic              pick_wr;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              capture;
    logic              if_ack;
    logic              d_ack;

    // Both strobes high together is a protocol error and is served as a write.
    assign d_req   = bus.d_rd_i | bus.d_wr_i;
    assign any_req = d_req | bus.if_req_i;
    assign grant   = (state_q == IDLE) && any_req;
    assign pick_wr = (gnt_pick == GNT_D) && bus.d_wr_i;

`ifdef MEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
    gnt_e last_q;

    // Starts at "data" so the first contested grant after reset goes to fetch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= GNT_D;
        end else if (grant) begin
            last_q <= gnt_pick;
        end
    end

    assign last_gnt = last_q;
`else
    localparam logic RR_EN = 1'b0;
    assign last_gnt = GNT_D;
`endif

    assign gnt_pick = arb_pick(d_req, bus.if_req_i, RR_EN, last_gnt);

    mem_lat_counter #(
        .W (CNT_W)
    ) u_lat (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (cnt_load),
        .load_val (CNT_W'(MEM_LAT)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = ISSUE;
                    cnt_load = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_dec = 1'b1;
            end
            WAIT: begin
                // Zero here means MEM_LAT cycles have elapsed since the strobe.
                if (cnt_zero) begin
                    state_d = ACK;
                    capture = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request address/data are taken only at the grant edge; requesters may change them later.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gnt_q   <= GNT_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (grant) begin
                gnt_q   <= gnt_pick;
                we_q    <= pick_wr;
                addr_q  <= (gnt_pick == GNT_D) ? bus.d_addr_i : bus.if_addr_i;
                wdata_q <= pick_wr ? bus.d_wdata_i : '0;
            end
            if (capture) begin
                data_q <= bus.mem_rdata_i;
            end
            if (bus.d_rd_i && bus.d_wr_i) begin
                err_q <= 1'b1;
            end
        end
    end

    assign if_ack = (state_q == ACK) && (gnt_q == GNT_IF);
    assign d_ack  = (state_q == ACK) && (gnt_q == GNT_D);

    assign bus.mem_en_o    = (state_q == ISSUE);
    assign bus.mem_we_o    = (state_q == ISSUE) && we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

    assign bus.if_ack_o    = if_ack;
    assign bus.d_ack_o     = d_ack;
    assign bus.if_rdata_o  = if_ack ? data_q : '0;
    assign bus.d_rdata_o   = (d_ack && !we_q) ? data_q : '0;
    assign bus.proto_err_o = err_q;

    // Stall holds while any live request is not being acknowledged this cycle.
    assign bus.stall_o = rst_i && ((bus.if_req_i && !if_ack) || (d_req && !d_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a cycle-count transaction model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;

    localparam int          MEM_LAT = 2;
    localparam int          AW      = 32;
    localparam int          DW      = 32;
    localparam logic [31:0] GARBAGE = 32'hA5A5_5A5A;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_bit(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory: fixed contents plus anything written ----------------
    logic [31:0] written [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (written.exists(a)) return written[a];
        if (a == 32'h40) return 32'h2008_0005;
        return a ^ 32'h1357_9BDF;
    endfunction

    int          lat_cnt = 0;
    logic [31:0] lat_addr = '0;

    // Read data is valid only for the one cycle that ends MEM_LAT edges after the strobe.
    always @(negedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) written[bus.mem_addr_o] = bus.mem_wdata_o;
            lat_cnt         = MEM_LAT;
            lat_addr        = bus.mem_addr_o;
            bus.mem_rdata_i = GARBAGE;
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            bus.mem_rdata_i = (lat_cnt == 0) ? mem_read(lat_addr) : GARBAGE;
        end else begin
            bus.mem_rdata_i = GARBAGE;
        end
    end

    // ---------------- transaction model ----------------
    // m_t counts cycles since the grant edge: 1 = strobe, MEM_LAT+2 = ack, MEM_LAT+3 = idle.
    bit          m_busy   = 1'b0;
    int          m_t      = 0;
    bit          m_who_d  = 1'b0;
    bit          m_last_d = 1'b1;
    bit          m_err    = 1'b0;
    logic        m_we     = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [31:0] m_rdata  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_t      = 0;
            m_err    = 1'b0;
            m_last_d = 1'b1;
        end else begin
            if (bus.d_rd_i && bus.d_wr_i) m_err = 1'b1;
            if (m_busy) begin
                m_t++;
                if (m_t == MEM_LAT + 3) m_busy = 1'b0;
            end else if (bus.if_req_i || bus.d_rd_i || bus.d_wr_i) begin
`ifdef MEM_ARB_RR_EN
                if ((bus.d_rd_i || bus.d_wr_i) && bus.if_req_i) m_who_d = !m_last_d;
                else m_who_d = bus.d_rd_i || bus.d_wr_i;
`else
                m_who_d = bus.d_rd_i || bus.d_wr_i;
`endif
                m_last_d = m_who_d;
                m_busy   = 1'b1;
                m_t      = 1;
                m_we     = m_who_d && bus.d_wr_i;
                m_addr   = m_who_d ? bus.d_addr_i : bus.if_addr_i;
                m_wdata  = bus.d_wdata_i;
                m_rdata  = m_we ? 32'h0 : mem_read(m_addr);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        logic e_en, e_ack, e_if_ack, e_d_ack, e_stall;
        if (!rst_n) begin
            check_bit ("rst mem_en",    bus.mem_en_o,    1'b0);
            check_bit ("rst mem_we",    bus.mem_we_o,    1'b0);
            check_bit ("rst if_ack",    bus.if_ack_o,    1'b0);
            check_bit ("rst d_ack",     bus.d_ack_o,     1'b0);
            check_bit ("rst stall",     bus.stall_o,     1'b0);
            check_bit ("rst proto_err", bus.proto_err_o, 1'b0);
            check_word("rst mem_addr",  bus.mem_addr_o,  32'h0);
            check_word("rst mem_wdata", bus.mem_wdata_o, 32'h0);
            check_word("rst if_rdata",  bus.if_rdata_o,  32'h0);
            check_word("rst d_rdata",   bus.d_rdata_o,   32'h0);
        end else begin
            e_en     = m_busy && (m_t == 1);
            e_ack    = m_busy && (m_t == MEM_LAT + 2);
            e_if_ack = e_ack && !m_who_d;
            e_d_ack  = e_ack && m_who_d;
            e_stall  = (bus.if_req_i && !e_if_ack) || ((bus.d_rd_i || bus.d_wr_i) && !e_d_ack);
            check_bit("mem_en",    bus.mem_en_o,    e_en);
            check_bit("if_ack",    bus.if_ack_o,    e_if_ack);
            check_bit("d_ack",     bus.d_ack_o,     e_d_ack);
            check_bit("stall",     bus.stall_o,     e_stall);
            check_bit("proto_err", bus.proto_err_o, m_err);
            if (e_en) begin
                check_bit ("mem_we",   bus.mem_we_o,   m_we);
                check_word("mem_addr", bus.mem_addr_o, m_addr);
                if (m_we) check_word("mem_wdata", bus.mem_wdata_o, m_wdata);
            end
            if (e_if_ack) check_word("if_rdata", bus.if_rdata_o, m_rdata);
            if (e_d_ack)  check_word("d_rdata",  bus.d_rdata_o,  m_rdata);
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [3:0] order;
        logic [3:0] exp_order;
        int         n;
        int         cyc;

        bus.if_req_i  = 1'b1;  // a request during reset must not raise stall
        bus.if_addr_i = 32'h0;
        bus.d_rd_i    = 1'b0;
        bus.d_wr_i    = 1'b0;
        bus.d_addr_i  = 32'h0;
        bus.d_wdata_i = 32'h0;
        repeat (3) step();
        check_bit("reset stall gated", bus.stall_o,  1'b0);
        check_bit("reset mem_en",      bus.mem_en_o, 1'b0);
        bus.if_req_i = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Fetch only
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h40;
        #1;
        check_bit("fetch stall C0", bus.stall_o, 1'b1);
        step();
        check_bit ("fetch mem_en C1", bus.mem_en_o,   1'b1);
        check_word("fetch addr C1",   bus.mem_addr_o, 32'h40);
        repeat (2) step();
        check_bit("fetch stall C3", bus.stall_o,  1'b1);
        check_bit("fetch ack C3",   bus.if_ack_o, 1'b0);
        step();
        check_bit ("fetch ack C4",   bus.if_ack_o,   1'b1);
        check_word("fetch rdata C4", bus.if_rdata_o, 32'h2008_0005);
        check_bit ("fetch stall C4", bus.stall_o,    1'b0);
        step();
        bus.if_req_i = 1'b0;
        repeat (2) step();

        // Collision: data first, fetch after
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h44;
        bus.d_rd_i    = 1'b1;
        bus.d_addr_i  = 32'h100;
        step();
        check_word("coll data addr C1", bus.mem_addr_o, 32'h100);
        repeat (3) step();
        check_bit ("coll d_ack C4",   bus.d_ack_o,   1'b1);
        check_word("coll d_rdata C4", bus.d_rdata_o, 32'h1357_9ADF);
        check_bit ("coll stall C4",   bus.stall_o,   1'b1);
        step();
        bus.d_rd_i = 1'b0;
        step();
        check_bit ("coll fetch en C6",   bus.mem_en_o,   1'b1);
        check_word("coll fetch addr C6", bus.mem_addr_o, 32'h44);
        repeat (3) step();
        check_bit ("coll if_ack C9",   bus.if_ack_o,   1'b1);
        check_word("coll if_rdata C9", bus.if_rdata_o, 32'h1357_9B9B);
        step();
        bus.if_req_i = 1'b0;
        repeat (2) step();

        // Store
        bus.d_wr_i    = 1'b1;
        bus.d_addr_i  = 32'h8;
        bus.d_wdata_i = 32'hDEAD_BEEF;
        step();
        check_bit ("store en C1",    bus.mem_en_o,    1'b1);
        check_bit ("store we C1",    bus.mem_we_o,    1'b1);
        check_word("store addr C1",  bus.mem_addr_o,  32'h8);
        check_word("store wdata C1", bus.mem_wdata_o, 32'hDEAD_BEEF);
        repeat (3) step();
        check_bit ("store ack C4",    bus.d_ack_o,   1'b1);
        check_word("store rdata C4",  bus.d_rdata_o, 32'h0);
        step();
        bus.d_wr_i = 1'b0;
        step();
        check_word("store reached memory", mem_read(32'h8), 32'hDEAD_BEEF);
        check_bit ("no proto_err yet",     bus.proto_err_o, 1'b0);
        step();

        // Protocol error: both strobes, served as a write
        bus.d_rd_i    = 1'b1;
        bus.d_wr_i    = 1'b1;
        bus.d_addr_i  = 32'hC;
        bus.d_wdata_i = 32'h0BAD_F00D;
        step();
        check_bit("perr we C1",  bus.mem_we_o,    1'b1);
        check_bit("perr flag",   bus.proto_err_o, 1'b1);
        repeat (3) step();
        check_bit("perr ack C4", bus.d_ack_o,     1'b1);
        step();
        bus.d_rd_i = 1'b0;
        bus.d_wr_i = 1'b0;
        repeat (3) step();
        check_bit("perr sticky", bus.proto_err_o, 1'b1);

        // Reset during WAIT abandons the access; the held fetch re-issues
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h40;
        step();
        check_bit("rstw en C1", bus.mem_en_o, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        check_bit("rstw stall now",    bus.stall_o,     1'b0);
        check_bit("rstw proto_err",    bus.proto_err_o, 1'b0);
        check_bit("rstw if_ack now",   bus.if_ack_o,    1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_bit ("rstw reissue en",   bus.mem_en_o,   1'b1);
        check_word("rstw reissue addr", bus.mem_addr_o, 32'h40);
        repeat (3) step();
        check_bit ("rstw if_ack",   bus.if_ack_o,   1'b1);
        check_word("rstw if_rdata", bus.if_rdata_o, 32'h2008_0005);
        step();
        bus.if_req_i = 1'b0;
        repeat (2) step();

        // Both held for four grants; the last grant before this was a fetch
`ifdef MEM_ARB_RR_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        order         = 4'b0000;
        n             = 0;
        cyc           = 0;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h48;
        bus.d_rd_i    = 1'b1;
        bus.d_addr_i  = 32'h104;
        while (n < 4 && cyc < 200) begin
            step();
            cyc++;
            if (bus.d_ack_o) begin
                order[n] = 1'b1;
                n++;
            end else if (bus.if_ack_o) begin
                order[n] = 1'b0;
                n++;
            end
        end
        check_word("rr ack count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_bit($sformatf("grant order %0d", i), order[i], exp_order[i]);
        end
        step();
        bus.if_req_i = 1'b0;
        bus.d_rd_i   = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
